// File: rtl/pc_pkg.sv
// Shared constants for the fetch program-counter unit.
// Holds next-PC select encodings and default sizing.
package pc_pkg;

    localparam int PC_WIDTH = 64;
    localparam logic [63:0] PC_RESET_VECTOR = 64'h0;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_SEQ  = 2'b01;
    localparam logic [1:0] PS_ABS  = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack.
// Pushing when full overwrites the oldest entry.
module return_stack #(
    parameter int WIDTH     = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, prev, wr_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             unf_q, unf_d, wr_en;

    assign prev      = ptr_q - PW'(1);
    assign top       = mem_q[prev];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(RAS_DEPTH));
    assign underflow = unf_q;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        unf_d  = pop & empty;
        if (push && pop && !empty) begin
            // Return and call in one cycle: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = prev;
        end else if (pop && !empty) begin
            ptr_d = prev;
            cnt_d = cnt_q - CW'(1);
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (!full) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            unf_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            unf_q <= unf_d;
            if (wr_en) mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with next-PC select,
// alignment check and a return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int               INSTR_BYTES  = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [1:0]       PS,
    input  logic [WIDTH-1:0] in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misaligned,
    output logic             underflow
);

    localparam int               SH       = $clog2(INSTR_BYTES);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);

    logic [WIDTH-1:0] pc_q, pc_d, ras_top, target;
    logic             mis_q, mis_d, take_ras, chk;

    assign PC         = pc_q;
    assign PC4        = pc_q + WIDTH'(INSTR_BYTES);
    assign misaligned = mis_q;

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push & ~stall),
        .pop       (pop & ~stall),
        .wdata     (PC4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .underflow (underflow)
    );

    always_comb begin
        take_ras = pop && !ras_empty;
        unique case (PS)
            PS_HOLD: target = pc_q;
            PS_SEQ:  target = PC4;
            PS_ABS:  target = in;
            PS_REL:  target = PC4 + (in << SH);
            default: target = pc_q;
        endcase
        if (take_ras) target = ras_top;
        // Hold and sequential targets are aligned by construction.
        chk   = take_ras || PS[1];
        mis_d = !stall && chk && (|(target & LOW_MASK));
        pc_d  = stall ? pc_q : (target & ~LOW_MASK);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed table,
// hand-written RAS sequences and randomized model compare.
module tb_pc_unit;

    localparam logic [63:0] RV = 64'h100;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  PS = 2'b00;
    logic [63:0] in_v = '0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [63:0] PC, PC4;
    logic        ras_empty, ras_full, misaligned, underflow;

    int checks = 0;
    int failures = 0;

    pc_unit #(
        .WIDTH        (64),
        .RESET_VECTOR (RV),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .stall      (stall),
        .PS         (PS),
        .in         (in_v),
        .push       (push),
        .pop        (pop),
        .PC         (PC),
        .PC4        (PC4),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .misaligned (misaligned),
        .underflow  (underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(string tag, logic [63:0] pc, bit mis,
                             bit unf, bit emp, bit full);
        chk({tag, " PC"}, PC, pc);
        chk({tag, " PC4"}, PC4, pc + 64'd4);
        chk({tag, " misaligned"}, 64'(misaligned), 64'(mis));
        chk({tag, " underflow"}, 64'(underflow), 64'(unf));
        chk({tag, " ras_empty"}, 64'(ras_empty), 64'(emp));
        chk({tag, " ras_full"}, 64'(ras_full), 64'(full));
    endtask

    task automatic drive(bit st, logic [1:0] ps, logic [63:0] v,
                         bit pu, bit po);
        stall = st;
        PS    = ps;
        in_v  = v;
        push  = pu;
        pop   = po;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        stall = 0; PS = 0; in_v = 0; push = 0; pop = 0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_state("reset", RV, 0, 0, 1, 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Reference model: RAS as a bounded queue, oldest at the front.
    logic [63:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_mis, m_unf;

    task automatic model_step(bit st, logic [1:0] ps, logic [63:0] v,
                              bit pu, bit po);
        logic [63:0] pc4, tgt;
        bit popped;
        if (st) begin
            m_mis = 0;
            m_unf = 0;
            return;
        end
        pc4    = m_pc + 64'd4;
        popped = po && (m_q.size() > 0);
        m_unf  = po && (m_q.size() == 0);
        if (popped) tgt = m_q[$];
        else if (ps == 2'd0) tgt = m_pc;
        else if (ps == 2'd1) tgt = pc4;
        else if (ps == 2'd2) tgt = v;
        else tgt = pc4 + v * 64'd4;
        m_mis = (popped || ps >= 2'd2) && (tgt % 64'd4 != 0);
        if (popped && pu) m_q[m_q.size() - 1] = pc4;
        else if (popped) void'(m_q.pop_back());
        else if (pu) begin
            m_q.push_back(pc4);
            if (m_q.size() > 4) void'(m_q.pop_front());
        end
        m_pc = tgt - (tgt % 64'd4);
    endtask

    typedef struct {
        bit          st;
        logic [1:0]  ps;
        logic [63:0] v;
        bit          pu;
        bit          po;
        logic [63:0] pc;
        bit          mis;
        bit          unf;
        bit          emp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{0, 2'b01, 64'h0,    0, 0, 64'h104,  0, 0, 1};
        tbl[1]  = '{0, 2'b01, 64'h0,    0, 0, 64'h108,  0, 0, 1};
        tbl[2]  = '{0, 2'b01, 64'h0,    0, 0, 64'h10C,  0, 0, 1};
        tbl[3]  = '{0, 2'b10, 64'h200,  0, 0, 64'h200,  0, 0, 1};
        tbl[4]  = '{0, 2'b10, 64'h3002, 0, 0, 64'h3000, 1, 0, 1};
        tbl[5]  = '{0, 2'b11, 64'h4,    0, 0, 64'h3014, 0, 0, 1};
        tbl[6]  = '{0, 2'b10, 64'h1000, 0, 0, 64'h1000, 0, 0, 1};
        tbl[7]  = '{0, 2'b10, 64'h5000, 1, 0, 64'h5000, 0, 0, 0};
        tbl[8]  = '{0, 2'b00, 64'h0,    0, 1, 64'h1004, 0, 0, 1};
        tbl[9]  = '{0, 2'b01, 64'h0,    0, 1, 64'h1008, 0, 1, 1};
        tbl[10] = '{0, 2'b00, 64'h0,    0, 0, 64'h1008, 0, 0, 1};
        tbl[11] = '{0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
                    64'h1008, 0, 0, 1};
        tbl[12] = '{0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,
                    64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1};
        tbl[13] = '{0, 2'b01, 64'h0,    0, 0, 64'h0,    0, 0, 1};
        tbl[14] = '{1, 2'b10, 64'h777,  1, 0, 64'h0,    0, 0, 1};
        tbl[15] = '{1, 2'b10, 64'h777,  1, 1, 64'h0,    0, 0, 1};
        tbl[16] = '{0, 2'b10, 64'h777,  1, 0, 64'h774,  1, 0, 0};
        tbl[17] = '{0, 2'b00, 64'h0,    0, 1, 64'h4,    0, 0, 1};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].ps, tbl[i].v, tbl[i].pu, tbl[i].po);
            chk_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].mis,
                      tbl[i].unf, tbl[i].emp, 0);
        end

        // Overflow wrap: five calls into a four-entry stack.
        drive(0, 2'b10, 64'h10000, 0, 0);
        chk_state("wrap_base", 64'h10000, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b01, 64'h0, 1, 0);
            chk_state($sformatf("wrap_push%0d", i), 64'h10004 + 64'(4 * i),
                      0, 0, 0, i >= 3);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b10, 64'h9000, 0, 1);
            chk_state($sformatf("wrap_pop%0d", i), 64'h10014 - 64'(4 * i),
                      0, 0, i == 3, 0);
        end
        drive(0, 2'b10, 64'h9000, 0, 1);
        chk_state("wrap_pop_empty", 64'h9000, 0, 1, 1, 0);

        // Simultaneous push and pop, non-empty then empty.
        drive(0, 2'b01, 64'h0, 1, 0);
        chk_state("pp_push", 64'h9004, 0, 0, 0, 0);
        drive(0, 2'b10, 64'h0, 1, 1);
        chk_state("pp_both", 64'h9004, 0, 0, 0, 0);
        drive(0, 2'b00, 64'h0, 0, 1);
        chk_state("pp_pop", 64'h9008, 0, 0, 1, 0);
        drive(0, 2'b10, 64'h2000, 1, 1);
        chk_state("pp_both_empty", 64'h2000, 0, 1, 0, 0);
        drive(0, 2'b00, 64'h0, 0, 1);
        chk_state("pp_pop2", 64'h900C, 0, 0, 1, 0);

        // Asynchronous reset in the middle of a cycle.
        drive(0, 2'b01, 64'h0, 1, 0);
        chk_state("ar_push1", 64'h9010, 0, 0, 0, 0);
        drive(0, 2'b10, 64'h4443, 1, 0);
        chk_state("ar_push2", 64'h4440, 1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_state("ar_async", RV, 0, 0, 1, 0);
        stall = 0; PS = 0; in_v = 0; push = 0; pop = 0;
        @(negedge clock);
        reset_n = 1'b1;
        drive(0, 2'b01, 64'h0, 0, 0);
        chk_state("ar_after", RV + 64'd4, 0, 0, 1, 0);

        // Randomized run against the reference model.
        do_reset();
        m_pc  = RV;
        m_q.delete();
        m_mis = 0;
        m_unf = 0;
        for (int n = 0; n < 500; n++) begin
            bit          st, pu, po;
            logic [1:0]  ps;
            logic [63:0] v;
            st = ($urandom_range(0, 6) == 0);
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            ps = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) v = {$urandom, $urandom};
            else v = 64'($urandom_range(0, 'h3fff));
            model_step(st, ps, v, pu, po);
            drive(st, ps, v, pu, po);
            chk_state($sformatf("rnd%0d", n), m_pc, m_mis, m_unf,
                      m_q.size() == 0, m_q.size() == 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-issue program counter. Holds the fetch PC and produces PC and PC+INSTR_BYTES for the datapath and ROM.
- Next-PC select supports hold, sequential, absolute and PC-relative modes, plus a global stall.
- Adds a return-address stack (RAS) for call/return.
- Sits between control (PS, push/pop, stall) and the instruction ROM address.

Parameters:
- WIDTH, 64, PC/data width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment; power of two.
- RAS_DEPTH, 4, return-address stack entries; power of two, >=2.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  1 = freeze PC and RAS this cycle.
- PS  in  2  next-PC select: 00 hold, 01 PC4, 10 in (absolute), 11 PC4 + (in << log2(INSTR_BYTES)).
- in  in  WIDTH  target or offset operand.
- push  in  1  call: save PC4 on RAS.
- pop  in  1  return: next PC = RAS top.
- PC  out  WIDTH  current PC (registered).
- PC4  out  WIDTH  PC + INSTR_BYTES (combinational from PC).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- misaligned  out  1  registered one-cycle pulse: last loaded target had nonzero low bits.
- underflow  out  1  registered one-cycle pulse: pop issued while empty.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_VECTOR; RAS count=0, pointer=0.
  - misaligned=0, underflow=0, ras_empty=1, ras_full=0.
- Arithmetic:
  - All sums are modulo 2^WIDTH; carry is discarded.
  - Relative shift drops the upper bits of in.
- Next-PC, evaluated each rising edge when stall=0:
  - pop=1 and RAS non-empty: nextPC = RAS top; PS is ignored.
  - pop=1 and RAS empty: nextPC per PS; underflow=1 for one cycle.
  - pop=0: nextPC per PS encoding.
- Alignment:
  - Low log2(INSTR_BYTES) bits of nextPC are forced to 0 before loading.
  - misaligned=1 for one cycle if any forced bit was 1.
  - misaligned applies in modes 10 and 11 and on RAS pop.
- stall=1:
  - PC, RAS contents and pointers are unchanged.
  - push and pop are ignored.
  - misaligned and underflow return to 0 next cycle.
  - PC4 continues to track PC.
- Latency: PC updates one cycle after the select/operands are sampled. PC4 and the flags (ras_empty, ras_full) are combinational from registers.
- RAS is a circular LIFO:
  - push writes PC4 (pre-update value) at pointer and advances the pointer.
  - count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry (wrap); ras_full stays 1.
  - pop reads entry pointer-1, retreats the pointer and decrements count.
- Simultaneous push and pop (non-empty): nextPC = old top, top entry replaced by PC4, count unchanged.
- Simultaneous push and pop (empty): behaves as push plus underflow pulse; nextPC per PS.
- Reset mid-operation: all state returns to reset values immediately; any in-flight push is lost.

Decomposition:
- Shared package pc_pkg holds:
  - PS encodings: PS_HOLD=2'b00, PS_SEQ=2'b01, PS_ABS=2'b10, PS_REL=2'b11.
  - Default WIDTH and RESET_VECTOR constants.
- One sub-module, return_stack:
  - Parametrised by WIDTH and RAS_DEPTH.
  - Inputs: clock, reset_n, push, pop, wdata.
  - Outputs: top, empty, full, underflow.
  - pc_unit holds the PC register, adders, shift, next-PC mux and alignment check.

Test Plan:
- Reset with RESET_VECTOR=0x100, then PS=01 for 3 cycles -> PC 0x100, 0x104, 0x108, 0x10C; PC4 always PC+4; ras_empty=1.
- PC=0x200, PS=10, in=0x3002 -> PC=0x3000, misaligned=1 for one cycle. Then PS=11, in=0x4 -> PC=0x3000+4+0x10=0x3014.
- PC=0x1000, push=1 with PS=10, in=0x5000 -> PC=0x5000, RAS top=0x1004. Then pop=1 -> PC=0x1004, ras_empty=1.
- RAS_DEPTH=4: push 5 times with PC4 values A..E, then pop 5 times -> returns E, D, C, B. Fifth pop gives underflow=1 and PC follows PS.
- stall=1 for 3 cycles with PS=10, push=1 -> PC, RAS count and flags unchanged. Release stall -> normal update next edge.
- Assert reset_n=0 mid-cycle after 2 pushes -> PC=RESET_VECTOR immediately (before next edge), ras_empty=1, misaligned=0.
